// File: rtl/memory_access_controller_if.sv
// Command, write-beat, read-return and memory-side signals of the memory access controller.
// The slave modport is the controller view; master is the view of whoever drives it.
interface memory_access_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, mem_rdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           mem_addr, mem_cs, mem_read, mem_write, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, mem_rdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           mem_addr, mem_cs, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/memory_access_controller.sv
// Burst read/write/clear controller in front of a small single-port byte memory.
// Memory-side strobes are decoded from the state register so reset silences them at once.
module memory_access_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  memory_access_controller_if.slave   bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              last_beat;
  assign last_beat = (beats_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_d       = beats_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.mem_addr  = '0;
    bus.mem_cs    = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          beats_d = CNT_W'(bus.cmd_len) + CNT_W'(1);
          unique case (op_e'(bus.cmd_op))
            OP_READ:  state_d = S_READ;
            OP_WRITE: state_d = S_WRITE;
            OP_CLEAR: begin
              state_d = S_CLEAR;
              addr_d  = '0;
              beats_d = CNT_W'(DEPTH);
            end
            default:  state_d = S_DONE;
          endcase
        end
      end

      S_READ: begin
        bus.mem_cs   = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_addr = addr_q;
        rd_data_d    = bus.mem_rdata;
        rd_valid_d   = 1'b1;
        addr_d       = addr_q + ADDR_W'(1);
        beats_d      = beats_q - CNT_W'(1);
        if (last_beat) state_d = S_DONE;
      end

      S_WRITE: begin
        bus.wr_ready  = 1'b1;
        bus.mem_cs    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = bus.wr_data;
        bus.mem_write = bus.wr_valid;
        // An absent beat holds address and count so the burst resumes in place.
        if (bus.wr_valid) begin
          addr_d  = addr_q + ADDR_W'(1);
          beats_d = beats_q - CNT_W'(1);
          if (last_beat) state_d = S_DONE;
        end
      end

      S_CLEAR: begin
        bus.mem_cs    = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr_q;
        addr_d        = addr_q + ADDR_W'(1);
        beats_d       = beats_q - CNT_W'(1);
        if (last_beat) state_d = S_DONE;
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
